// File: rtl/mult_seq.sv
// Sequential shift-add multiplier: one partial-product row per clock, fixed WIDTH-cycle latency,
// run-time signed/unsigned mode via sign-magnitude conversion and valid/ready on both sides.
module mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             neg;
  logic [PW-1:0]    acc, row, sum;
  logic [CW-1:0]    count;
  logic             last, accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Row for the current multiplier bit; final row is folded straight into the product.
  assign last = (count == CW'(WIDTH - 1));
  assign row  = b_mag[count] ? (PW'(a_mag) << count) : '0;
  assign sum  = acc + row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_mag   <= '0;
      b_mag   <= '0;
      neg     <= 1'b0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
    end else if (accept) begin
      // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude.
      if (signed_mode) begin
        a_mag <= a[WIDTH-1] ? -a : a;
        b_mag <= b[WIDTH-1] ? -b : b;
        neg   <= a[WIDTH-1] ^ b[WIDTH-1];
      end else begin
        a_mag <= a;
        b_mag <= b;
        neg   <= 1'b0;
      end
      acc   <= '0;
      count <= '0;
    end else if (state == CALC) begin
      acc <= sum;
      if (last) product <= neg ? -sum : sum;
      else      count   <= count + CW'(1);
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq: one WIDTH=4 and one WIDTH=8 instance sharing clock and reset.
module tb_mult_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid4 = 0, in_ready4, sm4 = 0, out_valid4, out_ready4 = 1, busy4;
  logic [3:0] a4 = 0, b4 = 0;
  logic [7:0] product4;

  logic        in_valid8 = 0, in_ready8, sm8 = 0, out_valid8, out_ready8 = 1, busy8;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] product8;

  mult_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .signed_mode(sm4), .out_valid(out_valid4), .out_ready(out_ready4), .product(product4),
    .busy(busy4));

  mult_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .signed_mode(sm8), .out_valid(out_valid8), .out_ready(out_ready8), .product(product8),
    .busy(busy8));

  int n_chk = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ov4(output int k);
    k = 0;
    repeat (20) begin
      @(posedge clk); #1;
      k++;
      if (out_valid4) return;
    end
    k = 99;
  endtask

  task automatic wait_ov8(output int k);
    k = 0;
    repeat (30) begin
      @(posedge clk); #1;
      k++;
      if (out_valid8) return;
    end
    k = 99;
  endtask

  // One WIDTH=4 operation from IDLE with out_ready high.
  task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                     input logic sm, input logic [7:0] exp);
    int k;
    a4 = a; b4 = b; sm4 = sm; in_valid4 = 1; out_ready4 = 1;
    @(posedge clk); #1;
    in_valid4 = 0;
    chk({tag, "_in_ready_drop"}, in_ready4, 0);
    chk({tag, "_busy"}, busy4, 1);
    wait_ov4(k);
    chk({tag, "_latency"}, k, 4);
    chk({tag, "_product"}, product4, exp);
    @(posedge clk); #1;
    chk({tag, "_back_idle"}, in_ready4, 1);
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic sm, input logic [15:0] exp);
    int k;
    a8 = a; b8 = b; sm8 = sm; in_valid8 = 1; out_ready8 = 1;
    @(posedge clk); #1;
    in_valid8 = 0;
    wait_ov8(k);
    chk({tag, "_latency"}, k, 8);
    chk({tag, "_product"}, product8, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, last_acc, this_acc;
    logic [3:0] ea, eb;
    logic esm;
    logic [7:0] exp8;
    int p;
    logic signed [3:0] sa, sb;
    bit seen;

    #12;
    chk("rst_in_ready", in_ready8, 1);
    chk("rst_out_valid", out_valid8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_product", product8, 0);
    chk("rst_product4", product4, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // Directed WIDTH=4 vectors
    op4("u15x15", 4'hF, 4'hF, 0, 8'hE1);
    op4("s_m8xm8", 4'h8, 4'h8, 1, 8'h40);
    op4("s_m8x7", 4'h8, 4'h7, 1, 8'hC8);
    op4("s_3xm1", 4'h3, 4'hF, 1, 8'hFD);
    op4("s_0xm8", 4'h0, 4'h8, 1, 8'h00);

    // Exhaustive back-to-back, in_valid held high
    in_valid4 = 1; out_ready4 = 1;
    a4 = 0; b4 = 0; sm4 = 0;
    last_acc = 0;
    for (int idx = 0; idx < 512; idx++) begin
      ea = a4; eb = b4; esm = sm4;
      @(posedge clk); #1;
      this_acc = cyc;
      if (idx > 0) chk("exh_period", this_acc - last_acc, 6);
      last_acc = this_acc;
      if (idx == 511) in_valid4 = 0;
      else begin
        a4 = 4'((idx + 1) % 16);
        b4 = 4'(((idx + 1) / 16) % 16);
        sm4 = ((idx + 1) >= 256);
      end
      wait_ov4(k);
      if (esm) begin
        sa = ea; sb = eb;
        p = sa * sb;
      end else begin
        p = ea * eb;
      end
      exp8 = p[7:0];
      chk($sformatf("exh_%0d_%0h_%0h", esm, ea, eb), product4, exp8);
      @(posedge clk); #1;
    end

    // Backpressure on WIDTH=8
    a8 = 8'd200; b8 = 8'd100; sm8 = 0; in_valid8 = 1; out_ready8 = 0;
    @(posedge clk); #1;
    in_valid8 = 0;
    wait_ov8(k);
    chk("bp_latency", k, 8);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_product", product8, 16'h4E20);
      chk("bp_out_valid", out_valid8, 1);
      chk("bp_in_ready", in_ready8, 0);
    end
    out_ready8 = 1;
    @(posedge clk); #1;
    chk("bp_done_ov", out_valid8, 0);
    chk("bp_done_ir", in_ready8, 1);
    chk("bp_hold_product", product8, 16'h4E20);

    // Reset three edges after accept
    a8 = 8'd9; b8 = 8'd9; in_valid8 = 1;
    @(posedge clk); #1;
    in_valid8 = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_in_ready", in_ready8, 1);
    chk("mid_rst_busy", busy8, 0);
    chk("mid_rst_out_valid", out_valid8, 0);
    chk("mid_rst_product", product8, 0);
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid8) seen = 1;
    end
    chk("mid_rst_no_ov", seen, 0);
    op8("after_rst", 8'd2, 8'd3, 0, 16'd6);

    // Operand change during CALC is ignored
    a8 = 8'd5; b8 = 8'd6; sm8 = 0; in_valid8 = 1;
    @(posedge clk); #1;
    in_valid8 = 0; a8 = 8'hFF; b8 = 8'hFF; sm8 = 1;
    wait_ov8(k);
    chk("chg_latency", k, 8);
    chk("chg_product", product8, 16'd30);
    @(posedge clk); #1;

    op8("s8_m128xm128", 8'h80, 8'h80, 1, 16'h4000);
    op8("s8_m1x127", 8'hFF, 8'h7F, 1, 16'hFF81);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
